// File: rtl/easy_fifo_axis_gen.sv
// easy_fifo_axis_gen: AXI-Stream burst traffic source for the FIFO write side.
// Emits bursts of incrementing words with programmable length, gap and count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no run active, tvalid low, waiting for start
// ST_SEND | presenting beats, tvalid high, advancing on each handshake
// ST_GAP  | idle cycles between bursts, tvalid low, down-counting gap
module easy_fifo_axis_gen #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] burst_len_i,
  input  logic [CNT_WIDTH-1:0] gap_len_i,
  input  logic [CNT_WIDTH-1:0] num_bursts_i,
  input  logic [DWIDTH-1:0]    seed_i,
  output logic [DWIDTH-1:0]    m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          beat_total_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               state_q;
  logic [DWIDTH-1:0]    data_q;
  logic [31:0]          beat_total_q;
  logic [CNT_WIDTH-1:0] burst_len_q;
  logic [CNT_WIDTH-1:0] gap_len_q;
  logic [CNT_WIDTH-1:0] num_bursts_q;
  logic [CNT_WIDTH-1:0] beats_left_q;
  logic [CNT_WIDTH-1:0] gap_cnt_q;
  logic [CNT_WIDTH-1:0] bursts_done_q;
  logic                 stop_pend_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 hs;
  logic                 last_beat;
  logic                 run_complete;
  logic                 stop_req;
  logic [CNT_WIDTH-1:0] burst_len_d;
  logic [CNT_WIDTH-1:0] bursts_done_d;
  logic [DWIDTH-1:0]    data_d;

  // Handshake and end-of-burst/run decode; only registered state feeds outputs.
  always_comb begin
    hs            = valid_q & m_axis_tready_i;
    last_beat     = (beats_left_q == CNT_WIDTH'(1));
    bursts_done_d = bursts_done_q + CNT_WIDTH'(1);
    run_complete  = (num_bursts_q != '0) && (bursts_done_d == num_bursts_q);
    // A stop pulse seen while a beat is stalled is remembered until that beat goes.
    stop_req      = stop_i | stop_pend_q;
    burst_len_d   = (burst_len_i == '0) ? CNT_WIDTH'(1) : burst_len_i;
    data_d        = data_q + DWIDTH'(1);
  end

  // Sequencer: state, counters and registered stream/status outputs.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      beat_total_q  <= '0;
      burst_len_q   <= '0;
      gap_len_q     <= '0;
      num_bursts_q  <= '0;
      beats_left_q  <= '0;
      gap_cnt_q     <= '0;
      bursts_done_q <= '0;
      stop_pend_q   <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            burst_len_q   <= burst_len_d;
            gap_len_q     <= gap_len_i;
            num_bursts_q  <= num_bursts_i;
            beats_left_q  <= burst_len_d;
            data_q        <= seed_i;
            beat_total_q  <= '0;
            bursts_done_q <= '0;
            stop_pend_q   <= 1'b0;
            valid_q       <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop_i) stop_pend_q <= 1'b1;
          if (hs) begin
            data_q       <= data_d;
            beat_total_q <= beat_total_q + 32'd1;
            beats_left_q <= beats_left_q - CNT_WIDTH'(1);
            if (last_beat) bursts_done_q <= bursts_done_d;
            if ((last_beat && run_complete) || stop_req) begin
              state_q     <= ST_IDLE;
              valid_q     <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              stop_pend_q <= 1'b0;
            end else if (last_beat) begin
              if (gap_len_q == '0) begin
                beats_left_q <= burst_len_q;
              end else begin
                gap_cnt_q <= gap_len_q;
                valid_q   <= 1'b0;
                state_q   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == CNT_WIDTH'(1)) begin
            beats_left_q <= burst_len_q;
            valid_q      <= 1'b1;
            state_q      <= ST_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata_o  = data_q;
  assign m_axis_tvalid_o = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign beat_total_o    = beat_total_q;

endmodule

// File: tb/tb_easy_fifo_axis_gen.sv
// tb_easy_fifo_axis_gen: directed checks of burst timing, backpressure,
// data wrap, early stop and mid-run reset for easy_fifo_axis_gen.
module tb_easy_fifo_axis_gen;

  logic        clk_sys_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [15:0] burst_len_i = '0;
  logic [15:0] gap_len_i = '0;
  logic [15:0] num_bursts_i = '0;
  logic [31:0] seed_i = '0;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [31:0] beat_total_o;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc;
  int          done_cnt;
  int          stall_bad;
  logic        done_tvalid;
  logic        done_busy;

  easy_fifo_axis_gen dut (
    .clk_sys_i      (clk_sys_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .burst_len_i    (burst_len_i),
    .gap_len_i      (gap_len_i),
    .num_bursts_i   (num_bursts_i),
    .seed_i         (seed_i),
    .m_axis_tdata_o (m_axis_tdata_o),
    .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tready_i(m_axis_tready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .beat_total_o   (beat_total_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  // Pulse start for one edge; returns in the first cycle after start is sampled.
  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Observe a run: mode 0 keeps tready high, mode 1 toggles it starting high.
  task automatic run(input int max_cyc, input int mode);
    logic        prev_stall;
    logic [31:0] prev_data;
    got_data.delete();
    got_cyc.delete();
    done_cyc = 0;
    done_cnt = 0;
    stall_bad = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    done_tvalid = 1'b1;
    done_busy = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      m_axis_tready_i = (mode == 0) ? 1'b1 : ((c % 2) == 1);
      if (prev_stall && (!m_axis_tvalid_o || m_axis_tdata_o !== prev_data)) stall_bad++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          done_tvalid = m_axis_tvalid_o;
          done_busy = busy_o;
        end
      end
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        got_data.push_back(m_axis_tdata_o);
        got_cyc.push_back(c);
      end
      prev_stall = m_axis_tvalid_o & ~m_axis_tready_i;
      prev_data = m_axis_tdata_o;
      if (done_cyc != 0 && c >= done_cyc + 2) break;
      tick();
    end
    if (done_cyc == 0) chk("run_timeout", 32'd1, 32'd0);
    m_axis_tready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_tdata", m_axis_tdata_o, 32'h0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_beat_total", beat_total_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // 4-beat bursts, gap 2, two bursts, full throughput
    burst_len_i = 16'd4; gap_len_i = 16'd2; num_bursts_i = 16'd2; seed_i = 32'h10;
    start_run();
    chk("t1_first_tvalid", {31'd0, m_axis_tvalid_o}, 32'd1);
    chk("t1_first_busy", {31'd0, busy_o}, 32'd1);
    run(40, 0);
    chk("t1_nbeats", got_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_data.size()) begin
        chk($sformatf("t1_data%0d", i), got_data[i], 32'h10 + i);
        chk($sformatf("t1_cyc%0d", i), got_cyc[i], (i < 4) ? i + 1 : i + 3);
      end
    end
    chk("t1_done_cyc", done_cyc, 32'd11);
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_done_tvalid", {31'd0, done_tvalid}, 32'd0);
    chk("t1_done_busy", {31'd0, done_busy}, 32'd0);
    chk("t1_beat_total", beat_total_o, 32'd8);

    // Same run with tready toggling every cycle
    start_run();
    run(60, 1);
    chk("t2_nbeats", got_data.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_data.size()) chk($sformatf("t2_data%0d", i), got_data[i], 32'h10 + i);
    chk("t2_stall_stable", stall_bad, 32'd0);
    chk("t2_done_cyc", done_cyc, 32'd18);
    chk("t2_done_cnt", done_cnt, 32'd1);
    chk("t2_beat_total", beat_total_o, 32'd8);

    // burst_len 0 treated as 1, back-to-back, data wraps
    burst_len_i = 16'd0; gap_len_i = 16'd0; num_bursts_i = 16'd3; seed_i = 32'hFFFF_FFFE;
    start_run();
    run(20, 0);
    chk("t3_nbeats", got_data.size(), 32'd3);
    if (got_data.size() == 3) begin
      chk("t3_data0", got_data[0], 32'hFFFF_FFFE);
      chk("t3_data1", got_data[1], 32'hFFFF_FFFF);
      chk("t3_data2", got_data[2], 32'h0000_0000);
      chk("t3_cyc2", got_cyc[2], 32'd3);
    end
    chk("t3_done_cyc", done_cyc, 32'd4);
    chk("t3_beat_total", beat_total_o, 32'd3);

    // Endless run, stop pulse during a stall: pending beat must still go out
    burst_len_i = 16'd8; gap_len_i = 16'd0; num_bursts_i = 16'd0; seed_i = 32'h100;
    start_run();
    tick();
    tick();
    m_axis_tready_i = 1'b0;
    stop_i = 1'b1;
    chk("t4_stall_tvalid", {31'd0, m_axis_tvalid_o}, 32'd1);
    chk("t4_stall_tdata", m_axis_tdata_o, 32'h102);
    tick();
    stop_i = 1'b0;
    chk("t4_hold_tvalid", {31'd0, m_axis_tvalid_o}, 32'd1);
    chk("t4_hold_tdata", m_axis_tdata_o, 32'h102);
    chk("t4_hold_done", {31'd0, done_o}, 32'd0);
    tick();
    m_axis_tready_i = 1'b1;
    chk("t4_last_tvalid", {31'd0, m_axis_tvalid_o}, 32'd1);
    chk("t4_last_tdata", m_axis_tdata_o, 32'h102);
    tick();
    chk("t4_end_tvalid", {31'd0, m_axis_tvalid_o}, 32'd0);
    chk("t4_end_done", {31'd0, done_o}, 32'd1);
    chk("t4_end_busy", {31'd0, busy_o}, 32'd0);
    chk("t4_beat_total", beat_total_o, 32'd3);
    tick();
    chk("t4_done_once", {31'd0, done_o}, 32'd0);

    // start and stop together in IDLE: no run
    start_i = 1'b1;
    stop_i = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    chk("t5_ss_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_ss_tvalid", {31'd0, m_axis_tvalid_o}, 32'd0);
    tick();
    chk("t5_ss_busy2", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of SEND, then a fresh run from seed
    burst_len_i = 16'd4; gap_len_i = 16'd0; num_bursts_i = 16'd0; seed_i = 32'h55;
    start_run();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_rst_tdata", m_axis_tdata_o, 32'h0);
    chk("t6_rst_tvalid", {31'd0, m_axis_tvalid_o}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_rst_done", {31'd0, done_o}, 32'd0);
    chk("t6_rst_beat_total", beat_total_o, 32'd0);
    burst_len_i = 16'd2; num_bursts_i = 16'd1;
    start_run();
    chk("t6_restart_tdata", m_axis_tdata_o, 32'h55);
    chk("t6_restart_beat_total", beat_total_o, 32'd0);
    run(20, 0);
    chk("t6_nbeats", got_data.size(), 32'd2);
    if (got_data.size() == 2) chk("t6_data1", got_data[1], 32'h56);
    chk("t6_done_cyc", done_cyc, 32'd3);
    chk("t6_beat_total", beat_total_o, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
